// File: rtl/sng_ctrl_pkg.sv
// Shared types and helpers for the SNG early-termination controller.
package sng_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int unsigned MAX_W = 32;

  // Zero or anything past one LFSR period clamps to the full period.
  function automatic logic [MAX_W:0] eff_len(
    input logic [MAX_W:0] len,
    input int unsigned    w
  );
    logic [MAX_W:0] full;
    full = ((MAX_W+1)'(1) << w) - (MAX_W+1)'(1);
    if (len == '0 || len > full) return full;
    return len;
  endfunction

endpackage

// File: rtl/sng_bit_counter.sv
// Counts ones on bit_i while enabled; synchronous clear has priority.
module sng_bit_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         bit_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) count_d = '0;
    else if (en_i && bit_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/sng_et_ctrl.sv
// SNG stream-length controller: load, run L cycles, report ones count.
// Optional SNG_ET_ABORT_EN adds an abort input for early termination.
module sng_et_ctrl
  import sng_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
`ifdef SNG_ET_ABORT_EN
  input  logic                                abort,
`endif
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_INPUTS-1:0][WIDTH-1:0]    in_bxs,
  input  logic [WIDTH:0]                      in_len,
  output logic [NUM_INPUTS-1:0][WIDTH-1:0]    sng_bxs,
  output logic                                sng_restart,
  output logic                                sng_en,
  input  logic                                sc_bit,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [WIDTH:0]                      out_count,
  output logic [WIDTH:0]                      out_len
);

  state_e state_q, state_d;

  logic [WIDTH:0] len_q;
  logic [WIDTH:0] cyc_q;
  logic [WIDTH:0] cnt;
  logic [NUM_INPUTS-1:0][WIDTH-1:0] bxs_q;

  logic accept;
  logic in_run;
  logic stop;

  assign accept = (state_q == IDLE) && in_valid;
  assign in_run = (state_q == RUN);

`ifdef SNG_ET_ABORT_EN
  assign stop = abort &&
                ((state_q == LOAD) || (state_q == RUN));
`else
  assign stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN:  if (cyc_q == len_q - 1'b1) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = DONE;
  end

  always_comb begin
    in_ready    = 1'b0;
    sng_restart = 1'b0;
    sng_en      = 1'b0;
    out_valid   = 1'b0;
    out_count   = '0;
    out_len     = '0;
    unique case (1'b1)
      (state_q == IDLE): in_ready = 1'b1;
      (state_q == LOAD): sng_restart = 1'b1;
      (state_q == RUN):  sng_en = 1'b1;
      (state_q == DONE): begin
        out_valid = 1'b1;
        out_count = cnt;
        out_len   = cyc_q;
      end
      default: ;
    endcase
  end

  // cyc_q freezes outside RUN, so it is the run length seen in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q <= '0;
      cyc_q <= '0;
      bxs_q <= '0;
    end else if (accept) begin
      len_q <= (WIDTH+1)'(eff_len((MAX_W+1)'(in_len), WIDTH));
      cyc_q <= '0;
      bxs_q <= in_bxs;
    end else if (in_run) begin
      cyc_q <= cyc_q + 1'b1;
    end
  end

  assign sng_bxs = bxs_q;

  sng_bit_counter #(
    .W (WIDTH+1)
  ) u_ones (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (in_run),
    .clr_i   (accept),
    .bit_i   (sc_bit),
    .count_o (cnt)
  );

endmodule

// File: tb/tb_sng_et_ctrl.sv
// Directed self-checking bench for sng_et_ctrl (WIDTH=8, NUM_INPUTS=2).
module tb_sng_et_ctrl;

  logic            clk;
  logic            rst_n;
  logic            abort;
  logic            in_valid;
  logic            in_ready;
  logic [1:0][7:0] in_bxs;
  logic [8:0]      in_len;
  logic [1:0][7:0] sng_bxs;
  logic            sng_restart;
  logic            sng_en;
  logic            sc_bit;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_count;
  logic [8:0]      out_len;

  int checks;
  int failures;

  sng_et_ctrl #(
    .WIDTH      (8),
    .NUM_INPUTS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef SNG_ET_ABORT_EN
    .abort       (abort),
`endif
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bxs      (in_bxs),
    .in_len      (in_len),
    .sng_bxs     (sng_bxs),
    .sng_restart (sng_restart),
    .sng_en      (sng_en),
    .sc_bit      (sc_bit),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .out_len     (out_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       len;
    logic [7:0] b0;
    logic [7:0] b1;
    int       mode;
    int       ec;
    int       el;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  function automatic logic scf(input int mode, input int n);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return (n % 2) == 0;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_sng_en"}, 32'(sng_en), 0);
    chk({tag, "_restart"}, 32'(sng_restart), 0);
    chk({tag, "_bxs"}, 32'(sng_bxs), 0);
    chk({tag, "_count"}, 32'(out_count), 0);
    chk({tag, "_len"}, 32'(out_len), 0);
  endtask

  // Drives one accepted request; returns at the LOAD-cycle negedge.
  task automatic accept_job(input int len,
                            input logic [7:0] b0,
                            input logic [7:0] b1);
    chk("pre_in_ready", 32'(in_ready), 1);
    in_len   = 9'(len);
    in_bxs   = {b1, b0};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_bxs   = '0;
  endtask

  // Starts at the LOAD-cycle negedge and retires the result.
  task automatic finish_job(input int mode, input int ec,
                            input int el, input logic [15:0] eb);
    int n;
    chk("load_restart", 32'(sng_restart), 1);
    chk("load_sng_en", 32'(sng_en), 0);
    chk("load_in_ready", 32'(in_ready), 0);
    sc_bit = 1'b1;
    n = 0;
    @(negedge clk);
    if (sng_restart !== 1'b0)
      chk("restart_one_cycle", 32'(sng_restart), 0);
    while (sng_en === 1'b1 && n < 400) begin
      if (out_valid !== 1'b0)
        chk("run_out_valid", 32'(out_valid), 0);
      sc_bit = scf(mode, n);
      n++;
      @(negedge clk);
    end
    sc_bit = 1'b0;
    chk("run_cycles", 32'(n), 32'(el));
    chk("done_out_valid", 32'(out_valid), 1);
    chk("done_out_count", 32'(out_count), 32'(ec));
    chk("done_out_len", 32'(out_len), 32'(el));
    chk("done_bxs", 32'(sng_bxs), 32'(eb));
    chk("done_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_bxs_hold", 32'(sng_bxs), 32'(eb));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_bxs    = '0;
    in_len    = '0;
    sc_bit    = 1'b0;
    out_ready = 1'b0;

    vt[0] = '{16,  8'hA5, 8'h3C, 1, 16,  16};
    vt[1] = '{0,   8'h01, 8'hFF, 0, 0,   255};
    vt[2] = '{300, 8'h5A, 8'h77, 0, 0,   255};
    vt[3] = '{4,   8'h10, 8'h20, 2, 2,   4};
    vt[4] = '{1,   8'hC3, 8'h0F, 1, 1,   1};
    vt[5] = '{255, 8'h80, 8'h01, 2, 128, 255};
    vt[6] = '{256, 8'h33, 8'h44, 1, 255, 255};
    vt[7] = '{7,   8'hEE, 8'h11, 2, 4,   7};

    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_vals("rel");

    for (int i = 0; i < 8; i++) begin
      accept_job(vt[i].len, vt[i].b0, vt[i].b1);
      finish_job(vt[i].mode, vt[i].ec, vt[i].el,
                 {vt[i].b1, vt[i].b0});
    end

    // Stall in DONE, then exit with a simultaneous request.
    accept_job(3, 8'h12, 8'h34);
    sc_bit = 1'b1;
    for (int k = 0; k < 5; k++) @(negedge clk);
    sc_bit = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_out_count", 32'(out_count), 3);
      chk("stall_in_ready", 32'(in_ready), 0);
      in_len   = 9'd9;
      in_bxs   = {8'h99, 8'h88};
      in_valid = k[0];
      @(negedge clk);
    end
    chk("stall_bxs", 32'(sng_bxs), 32'h3412);
    chk("stall_still_done", 32'(out_valid), 1);
    in_len    = 9'd5;
    in_bxs    = {8'h56, 8'h78};
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("exit_idle_ready", 32'(in_ready), 1);
    chk("exit_no_restart", 32'(sng_restart), 0);
    @(negedge clk);
    in_valid = 1'b0;
    finish_job(1, 5, 5, 16'h5678);

    // Reset asserted at RUN cycle 10.
    accept_job(64, 8'hAB, 8'hCD);
    sc_bit = 1'b1;
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("mid_run_sng_en", 32'(sng_en), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    chk_reset_vals("midrst_hold");
    sc_bit = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    accept_job(4, 8'h01, 8'h02);
    finish_job(2, 2, 4, 16'h0201);

`ifdef SNG_ET_ABORT_EN
    accept_job(100, 8'h0A, 8'h0B);
    sc_bit = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 19) abort = 1'b1;
    end
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 1);
    chk("abort_out_len", 32'(out_len), 20);
    chk("abort_out_count", 32'(out_count), 20);
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done_hold", 32'(out_valid), 1);
    chk("abort_done_len", 32'(out_len), 20);
    sc_bit    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("abort_idle", 32'(in_ready), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/sng_et_ctrl.md
SNG_ET_CTRL -- requirements
Module: sng_et_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: LFSR/binary operand width.
REQ-002 Parameter NUM_INPUTS, default 2: number of SNG operands.
REQ-003 clk  input  1: clock, all state on rising edge.
REQ-004 rst_n  input  1: reset, asynchronous, active-low.
REQ-005 in_valid  input  1: job request.
REQ-006 in_ready  output  1: controller idle and able to accept a job.
REQ-007 in_bxs  input  NUM_INPUTS x WIDTH: binary operands for the job.
REQ-008 in_len  input  WIDTH+1: stream length in cycles; 0 means full period.
REQ-009 sng_bxs  output  NUM_INPUTS x WIDTH: latched operands driven to the SNG.
REQ-010 sng_restart  output  1: one-cycle strobe returning SNG LFSRs to start state.
REQ-011 sng_en  output  1: SNG advance enable.
REQ-012 sc_bit  input  1: stochastic result bit from downstream SC logic.
REQ-013 out_valid  output  1: result available.
REQ-014 out_ready  input  1: consumer accepts result.
REQ-015 out_count  output  WIDTH+1: number of 1s seen on sc_bit during RUN.
REQ-016 out_len  output  WIDTH+1: cycles actually run.

Function
REQ-017 FSM states IDLE, LOAD, RUN, DONE, encoded as a 2-bit enum.
REQ-018 IDLE: in_ready=1; on in_valid, latch in_bxs and effective length L, clear counters, go to LOAD.
REQ-019 Effective length: in_len=0 or in_len>2^WIDTH-1 gives L=2^WIDTH-1; otherwise L=in_len.
REQ-020 LOAD: sng_restart=1 for exactly one cycle, sng_en=0, then go to RUN.
REQ-021 RUN: sng_en=1; each cycle cyc increments and, when sc_bit=1, count increments; after the L-th RUN cycle go to DONE.
REQ-022 Latency: accept at edge t gives LOAD in cycle t+1, RUN in cycles t+2..t+1+L, out_valid=1 from cycle t+2+L.
REQ-023 DONE: out_valid=1, out_count=count, out_len=L, sng_en=0; hold stable until out_ready=1, then go to IDLE.
REQ-024 in_ready=0 in LOAD, RUN and DONE; in_valid is ignored there.
REQ-025 Same-cycle DONE exit and new in_valid: the request is accepted no earlier than the next IDLE cycle.
REQ-026 sng_bxs holds latched operands from accept until the next accept.
REQ-027 Counters are WIDTH+1 bits and never wrap, since count<=L<=2^WIDTH-1.

Reset
REQ-028 On rst_n low, at any time including mid-RUN: state=IDLE, in_ready=1, out_valid=0, sng_en=0, sng_restart=0, sng_bxs=0, out_count=0, out_len=0, counters=0.
REQ-029 No partial result is reported after reset.

Configuration
REQ-030 Macro SNG_ET_ABORT_EN defined: add input abort (1 bit). Abort=1 in LOAD or RUN goes to DONE next cycle, with out_len=cycles run so far and out_count=ones so far. Abort is ignored in IDLE and DONE.
REQ-031 Macro SNG_ET_ABORT_EN undefined: no abort port, and behaviour is exactly as REQ-017..027.

Structure
REQ-032 Package sng_ctrl_pkg holds the state enum typedef and the function computing effective length.
REQ-033 Sub-module sng_bit_counter (enable, clear, bit in, WIDTH+1 count out) is instantiated for the ones count.

Verification
REQ-034 Reset release: in_ready=1, out_valid=0, sng_en=0, out_count=0.
REQ-035 in_len=16, sc_bit=1 constant, accept at t: sng_restart pulse at t+1, sng_en high 16 cycles, out_valid at t+18, out_count=16, out_len=16.
REQ-036 in_len=0, sc_bit=0: 255 RUN cycles, out_count=0, out_len=255; in_len=300 gives the same result.
REQ-037 out_ready low 5 cycles in DONE: out_valid and out_count stable, in_ready=0, in_valid pulses ignored; returns to IDLE after out_ready=1.
REQ-038 rst_n low at RUN cycle 10 of in_len=64: all outputs take reset values immediately; next job in_len=4 with sc_bit alternating gives out_count=2.
REQ-039 With SNG_ET_ABORT_EN, in_len=100 with abort at RUN cycle 20 and sc_bit=1 gives out_len=20 and out_count=20.
